// File: rtl/fns_coder_ctrl.sv
// rtl/fns_coder_ctrl.sv - sequences NGRP data chunks through a shared 1-cycle coder and assembles the codeword
module fns_coder_ctrl #(
  parameter int DATA_W = 6,
  parameter int CODE_W = 9,
  parameter int NGRP   = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NGRP*DATA_W-1:0]   in_data,
  input  logic                     cfg_we,
  input  logic [1:0]               cfg_grp,
  input  logic [CODE_W-1:0]        cfg_mask,
  output logic [DATA_W-1:0]        cdr_datain,
  output logic [CODE_W-1:0]        cdr_en_flag,
  input  logic [CODE_W-1:0]        cdr_codeout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NGRP*CODE_W-1:0]   out_code,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_e;

  state_e                   state_q, state_d;
  logic [1:0]               idx_q, idx_d;
  logic [NGRP*DATA_W-1:0]   data_q;
  logic [NGRP*CODE_W-1:0]   code_q;
  logic [CODE_W-1:0]        mask_q [NGRP];
  logic [CODE_W-1:0]        snap_q [NGRP];
  logic                     accept;
  logic                     cap_en;
  logic [1:0]               cap_slot;

  assign accept = (state_q == IDLE) && in_valid;

  // The coder output lags its input by one cycle, so each capture targets the previous index.
  assign cap_en   = ((state_q == RUN) && (idx_q != 2'd0)) || (state_q == DRAIN);
  assign cap_slot = (state_q == DRAIN) ? 2'(NGRP - 1) : (idx_q - 2'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          idx_d   = 2'd0;
        end
      end
      RUN: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'(NGRP - 1)) state_d = DRAIN;
      end
      DRAIN: state_d = OUT;
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = (state_q != IDLE);
    cdr_datain  = '0;
    cdr_en_flag = '0;
    out_code    = code_q;
    case (state_q)
      IDLE: in_ready = 1'b1;
      RUN: begin
        cdr_datain  = data_q[idx_q*DATA_W +: DATA_W];
        cdr_en_flag = snap_q[idx_q];
      end
      OUT: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Snapshot reads mask_q before this edge's cfg write lands, so a same-edge write affects the next word only.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_q <= '0;
      code_q <= '0;
      for (int g = 0; g < NGRP; g++) begin
        mask_q[g] <= '1;
        snap_q[g] <= '0;
      end
    end else begin
      if (cfg_we) mask_q[cfg_grp] <= cfg_mask;
      if (accept) begin
        data_q <= in_data;
        for (int g = 0; g < NGRP; g++) snap_q[g] <= mask_q[g];
      end
      if (cap_en) code_q[cap_slot*CODE_W +: CODE_W] <= cdr_codeout;
    end
  end

endmodule

// File: tb/tb_fns_coder_ctrl.sv
// tb/tb_fns_coder_ctrl.sv - directed self-checking bench for fns_coder_ctrl with a registered coder stub
module tb_fns_coder_ctrl;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        cfg_we;
  logic [1:0]  cfg_grp;
  logic [8:0]  cfg_mask;
  logic [5:0]  cdr_datain;
  logic [8:0]  cdr_en_flag;
  logic [8:0]  cdr_codeout;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] out_code;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  fns_coder_ctrl #(.DATA_W(6), .CODE_W(9), .NGRP(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .cfg_we      (cfg_we),
    .cfg_grp     (cfg_grp),
    .cfg_mask    (cfg_mask),
    .cdr_datain  (cdr_datain),
    .cdr_en_flag (cdr_en_flag),
    .cdr_codeout (cdr_codeout),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_code    (out_code),
    .busy        (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always_ff @(posedge clock) cdr_codeout <= {3'b000, cdr_datain};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic accept_word(input logic [23:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [5:0] exp_chunk [4];
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    cfg_we    = 1'b0;
    cfg_grp   = '0;
    cfg_mask  = '0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready",  in_ready,    1);
    chk("rst_out_valid", out_valid,   0);
    chk("rst_busy",      busy,        0);
    chk("rst_en_flag",   cdr_en_flag, 0);
    chk("rst_out_code",  out_code,    0);
    reset = 1'b0;
    step();
    chk("idle_in_ready", in_ready, 1);

    // Word 1: chunk order, alignment, backpressure
    exp_chunk[0] = 6'h3F; exp_chunk[1] = 6'h00; exp_chunk[2] = 6'h15; exp_chunk[3] = 6'h2A;
    accept_word(24'hA9503F);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("w1_datain%0d", i), cdr_datain, exp_chunk[i]);
      chk($sformatf("w1_en%0d", i), cdr_en_flag, 9'h1FF);
      chk($sformatf("w1_busy%0d", i), busy, 1);
      chk($sformatf("w1_valid%0d", i), out_valid, 0);
      step();
    end
    chk("w1_drain_valid",  out_valid,   0);
    chk("w1_drain_datain", cdr_datain,  0);
    chk("w1_drain_en",     cdr_en_flag, 0);
    step();
    chk("w1_out_valid", out_valid, 1);
    chk("w1_out_code",  out_code,  {9'h02A, 9'h015, 9'h000, 9'h03F});
    in_valid = 1'b1;
    in_data  = 24'h000000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("bp_valid%0d", i), out_valid, 1);
      chk($sformatf("bp_code%0d", i),  out_code,  {9'h02A, 9'h015, 9'h000, 9'h03F});
      chk($sformatf("bp_ready%0d", i), in_ready,  0);
      chk($sformatf("bp_busy%0d", i),  busy,      1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hs_in_ready",  in_ready,  1);
    chk("hs_out_valid", out_valid, 0);
    chk("hs_busy",      busy,      0);
    chk("hs_code_hold", out_code,  {9'h02A, 9'h015, 9'h000, 9'h03F});

    // Word 2: mask write during RUN must not disturb the word in flight
    accept_word(24'hFFFFFF);
    chk("w2_en0", cdr_en_flag, 9'h1FF);
    step();
    cfg_we = 1'b1; cfg_grp = 2'd2; cfg_mask = 9'h0FF;
    step();
    cfg_we = 1'b0;
    chk("w2_en2_snapshot", cdr_en_flag, 9'h1FF);
    step();
    step();
    step();
    chk("w2_out_code", out_code, {4{9'h03F}});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Word 3: write on the accept edge uses pre-write value for this word
    cfg_we = 1'b1; cfg_grp = 2'd0; cfg_mask = 9'h00F;
    accept_word(24'h123456);
    cfg_we = 1'b0;
    chk("w3_en0_prewrite", cdr_en_flag, 9'h1FF);
    step();
    step();
    chk("w3_en2_new", cdr_en_flag, 9'h0FF);
    step();
    step();
    step();
    chk("w3_out_valid", out_valid, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Word 4: reset mid-RUN at idx=2
    accept_word(24'h654321);
    chk("w4_en0_new", cdr_en_flag, 9'h00F);
    step();
    step();
    chk("w4_en2", cdr_en_flag, 9'h0FF);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_busy",      busy,      0);
    chk("mr_in_ready",  in_ready,  1);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_out_code",  out_code,  0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("mr_no_valid%0d", i), out_valid, 0);
    end

    // Word 5: masks restored to all-ones
    accept_word(24'h820820);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("w5_en%0d", i), cdr_en_flag, 9'h1FF);
      chk($sformatf("w5_datain%0d", i), cdr_datain, 6'h20);
      step();
    end
    step();
    chk("w5_out_valid", out_valid, 1);
    chk("w5_out_code",  out_code,  {4{9'h020}});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("w5_idle", in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
